uart_rx_deser: RTL and testbench

- Serial receive front end of the UART. Deserialises the asynchronous rxd line using the 16x baud tick from the baud generator.
- Validates the start, data, parity and stop bits and checks for break.
- Delivers each character as a one-cycle push (rx_valid, rx_data, rx_err) into the RX FIFO. The FIFO is always treated as ready; overrun is flagged downstream.

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_rx_deser_if.sv | 11 +
 rtl/uart_rx_deser.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_deser.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: the per-character receive error flags pushed into the RX FIFO.
package uart_pkg;

    typedef struct packed {
        logic break_int;
        logic frame_err;
        logic parity_err;
    } rx_err_s;

endpackage

// File: rtl/uart_rx_deser_if.sv
// Push bus from the receive deserialiser into the RX FIFO (always ready, no back-pressure).
interface uart_rx_deser_if;

    logic                rx_valid;
    logic [7:0]          rx_data;
    uart_pkg::rx_err_s   rx_err;

    modport master (output rx_valid, output rx_data, output rx_err);
    modport slave  (input  rx_valid, input  rx_data, input  rx_err);

endinterface

// File: rtl/uart_rx_deser.sv
// UART receive deserialiser: 16x oversampled start/data/parity/stop framing with break detection.
// Optional UART_RX_MAJORITY_VOTE_EN: each bit is the 2-of-3 majority of the last three tick samples.
module uart_rx_deser #(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              baud_tick,
    input  logic              rxd,
    input  logic [1:0]        cfg_word_len,
    input  logic              cfg_parity_en,
    input  logic              cfg_parity_even,
    input  logic              cfg_parity_stick,
    uart_rx_deser_if.master   rx,
    output logic              rx_busy
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_START      = 3'd1;
    localparam logic [2:0] S_DATA       = 3'd2;
    localparam logic [2:0] S_PARITY     = 3'd3;
    localparam logic [2:0] S_STOP       = 3'd4;
    localparam logic [2:0] S_BREAK_WAIT = 3'd5;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxd_s;
    logic                   bit_val;

    logic [2:0]        state;
    logic [3:0]        tick_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift_q;
    logic [1:0]        f_len;
    logic              f_par_en;
    logic              f_par_even;
    logic              f_par_stick;
    logic              par_bit_q;
    logic              par_err_q;
    logic              valid_q;
    logic [7:0]        data_q;
    uart_pkg::rx_err_s err_q;

    logic [2:0]        last_bit;
    logic              par_exp;
    logic              is_break;
    logic              at_sample;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
        end
    end

    assign rxd_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_VOTE_EN
    // History shifts every tick, so at a sample point it holds the two preceding ticks.
    logic [1:0] hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 2'b11;
        end else if (baud_tick) begin
            hist_q <= {hist_q[0], rxd_s};
        end
    end

    assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxd_s) | (hist_q[0] & rxd_s);
`else
    assign bit_val = rxd_s;
`endif

    assign last_bit  = 3'd4 + {1'b0, f_len};
    assign par_exp   = f_par_stick ? ~f_par_even : (f_par_even ? ^shift_q : ~^shift_q);
    assign is_break  = (shift_q == 8'd0) && !bit_val && (!f_par_en || !par_bit_q);
    assign at_sample = (tick_cnt == 4'd15);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shift_q     <= '0;
            f_len       <= '0;
            f_par_en    <= 1'b0;
            f_par_even  <= 1'b0;
            f_par_stick <= 1'b0;
            par_bit_q   <= 1'b0;
            par_err_q   <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            err_q       <= '0;
        end else begin
            valid_q <= 1'b0;
            if (baud_tick) begin
                case (state)
                    S_IDLE: begin
                        tick_cnt <= '0;
                        if (!rxd_s) state <= S_START;
                    end
                    S_START: begin
                        if (tick_cnt == 4'd7) begin
                            if (bit_val) begin
                                state <= S_IDLE;
                            end else begin
                                f_len       <= cfg_word_len;
                                f_par_en    <= cfg_parity_en;
                                f_par_even  <= cfg_parity_even;
                                f_par_stick <= cfg_parity_stick;
                                shift_q     <= '0;
                                bit_cnt     <= '0;
                                par_bit_q   <= 1'b0;
                                par_err_q   <= 1'b0;
                                tick_cnt    <= '0;
                                state       <= S_DATA;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                    S_DATA: begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (at_sample) begin
                            shift_q[bit_cnt] <= bit_val;
                            if (bit_cnt == last_bit) begin
                                state <= f_par_en ? S_PARITY : S_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    S_PARITY: begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (at_sample) begin
                            par_bit_q <= bit_val;
                            par_err_q <= (bit_val != par_exp);
                            state     <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (at_sample) begin
                            valid_q <= 1'b1;
                            if (is_break) begin
                                data_q           <= 8'd0;
                                err_q.break_int  <= 1'b1;
                                err_q.frame_err  <= 1'b1;
                                err_q.parity_err <= 1'b0;
                                state            <= S_BREAK_WAIT;
                            end else begin
                                data_q           <= shift_q;
                                err_q.break_int  <= 1'b0;
                                err_q.frame_err  <= !bit_val;
                                err_q.parity_err <= f_par_en && par_err_q;
                                state            <= S_IDLE;
                            end
                        end
                    end
                    S_BREAK_WAIT: begin
                        if (rxd_s) state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign rx.rx_valid = valid_q;
    assign rx.rx_data  = data_q;
    assign rx.rx_err   = err_q;
    assign rx_busy     = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Self-checking bench for uart_rx_deser: directed framing cases plus randomized frames against a frame-level model.
module tb_uart_rx_deser;

    typedef struct {
        logic [7:0]  data;
        logic [2:0]  err;
        logic        busy;
        int unsigned tick;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        baud_tick;
    logic        rxd;
    logic [1:0]  cfg_word_len;
    logic        cfg_parity_en;
    logic        cfg_parity_even;
    logic        cfg_parity_stick;
    logic        rx_busy;

    int          n_cmp;
    int          n_bad;
    int unsigned tick_count;
    exp_t        exp_q[$];

    uart_rx_deser_if rx_if ();

    uart_rx_deser #(.SYNC_STAGES(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .baud_tick        (baud_tick),
        .rxd              (rxd),
        .cfg_word_len     (cfg_word_len),
        .cfg_parity_en    (cfg_parity_en),
        .cfg_parity_even  (cfg_parity_even),
        .cfg_parity_stick (cfg_parity_stick),
        .rx               (rx_if),
        .rx_busy          (rx_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One baud tick every four clocks, raised on the falling edge.
    initial begin
        int div;
        div        = 0;
        baud_tick  = 1'b0;
        tick_count = 0;
        forever begin
            @(negedge clk);
            if (div == 3) begin
                div        = 0;
                baud_tick  = 1'b1;
                tick_count = tick_count + 1;
            end else begin
                div       = div + 1;
                baud_tick = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp = n_cmp + 1;
        if (obs !== expv) begin
            n_bad = n_bad + 1;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic nextTick();
        @(posedge clk);
        while (!baud_tick) @(posedge clk);
        #2;
    endtask

    task automatic driveLevel(input logic level, input int n);
        rxd = level;
        repeat (n) nextTick();
    endtask

    function automatic exp_t modelFrame(input logic [1:0] len, input logic pen, input logic even,
                                        input logic stick, input logic [7:0] data,
                                        input logic pbit, input logic stop);
        exp_t       r;
        logic [7:0] mask;
        logic [7:0] d;
        logic       pexp;
        logic       brk;
        mask = 8'hFF >> (2'd3 - len);
        d    = data & mask;
        pexp = stick ? !even : (even ? ^d : !(^d));
        brk  = (d == 8'd0) && !stop && (!pen || !pbit);
        r.tick = 0;
        if (brk) begin
            r.data = 8'd0;
            r.err  = 3'b110;
            r.busy = 1'b1;
        end else begin
            r.data = d;
            r.err  = {1'b0, !stop, pen && (pbit != pexp)};
            r.busy = 1'b0;
        end
        return r;
    endfunction

    // Sends one frame starting right after the current tick and queues the expected push.
    task automatic applyStimulus(input logic [1:0] len, input logic pen, input logic even,
                                 input logic stick, input logic [7:0] data, input logic pbit,
                                 input logic stop, input int stop_ticks, input int gap,
                                 input logic glitch0);
        exp_t e;
        int   n;
        n                = int'(len) + 5;
        cfg_word_len     = len;
        cfg_parity_en    = pen;
        cfg_parity_even  = even;
        cfg_parity_stick = stick;
        e      = modelFrame(len, pen, even, stick, data, pbit, stop);
        e.tick = tick_count + 1 + 8 + 16 * (1 + n + int'(pen));
        exp_q.push_back(e);
        driveLevel(1'b0, 16);
        cfg_word_len     = 2'($urandom_range(0, 3));
        cfg_parity_en    = 1'($urandom_range(0, 1));
        cfg_parity_even  = 1'($urandom_range(0, 1));
        cfg_parity_stick = 1'($urandom_range(0, 1));
        for (int b = 0; b < n; b++) begin
            if (glitch0 && b == 0) begin
                driveLevel(data[0], 7);
                driveLevel(!data[0], 1);
                driveLevel(data[0], 8);
            end else begin
                driveLevel(data[b], 16);
            end
        end
        if (pen) driveLevel(pbit, 16);
        driveLevel(stop, stop_ticks);
        if (gap > 0) driveLevel(1'b1, gap);
    endtask

    initial begin : monitor
        logic prev_valid;
        logic [2:0] err_obs;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (prev_valid) checkOutput("valid_width", 32'(rx_if.rx_valid), 32'd0);
            prev_valid = rx_if.rx_valid;
            if (rx_if.rx_valid) begin
                checkOutput("push_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e       = exp_q.pop_front();
                    err_obs = rx_if.rx_err;
                    checkOutput("push_data", 32'(rx_if.rx_data), 32'(e.data));
                    checkOutput("push_err",  32'(err_obs),       32'(e.err));
                    checkOutput("push_busy", 32'(rx_busy),       32'(e.busy));
                    checkOutput("push_tick", 32'(tick_count),    32'(e.tick));
                end
            end
        end
    end

    initial begin : stimulus
        logic [1:0] r_len;
        logic       r_pen, r_even, r_stick, r_pbit, r_stop;
        logic [7:0] r_data;
        logic [2:0] err_obs;
        int         r_stop_ticks, r_gap;

        n_cmp            = 0;
        n_bad            = 0;
        rst_n            = 1'b0;
        rxd              = 1'b1;
        cfg_word_len     = 2'b11;
        cfg_parity_en    = 1'b0;
        cfg_parity_even  = 1'b0;
        cfg_parity_stick = 1'b0;

        repeat (3) @(negedge clk);
        err_obs = rx_if.rx_err;
        checkOutput("reset_valid", 32'(rx_if.rx_valid), 32'd0);
        checkOutput("reset_data",  32'(rx_if.rx_data),  32'd0);
        checkOutput("reset_err",   32'(err_obs),        32'd0);
        checkOutput("reset_busy",  32'(rx_busy),        32'd0);
        rst_n = 1'b1;
        nextTick();
        driveLevel(1'b1, 8);

        $display("[TB] directed frames");
        applyStimulus(2'b11, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 16, 16, 1'b0);
        applyStimulus(2'b10, 1'b1, 1'b1, 1'b0, 8'h41, 1'b1, 1'b1, 16, 16, 1'b0);
        applyStimulus(2'b10, 1'b1, 1'b1, 1'b0, 8'h41, 1'b0, 1'b1, 16, 16, 1'b0);

        // False start: short low glitch must not produce a character.
        driveLevel(1'b0, 4);
        checkOutput("glitch_busy_high", 32'(rx_busy), 32'd1);
        driveLevel(1'b1, 20);
        checkOutput("glitch_busy_clear", 32'(rx_busy), 32'd0);

        applyStimulus(2'b11, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 16, 16, 1'b0);
        applyStimulus(2'b11, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 16, 16, 1'b0);

        // Break lasting several frame times, then a clean 8E1 character.
        applyStimulus(2'b11, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16 * 20, 16, 1'b0);
        checkOutput("break_exit_busy", 32'(rx_busy), 32'd0);
        checkOutput("break_hold_data", 32'(rx_if.rx_data), 32'd0);
        applyStimulus(2'b11, 1'b1, 1'b1, 1'b0, 8'h12, 1'b0, 1'b1, 16, 16, 1'b0);

        // Back-to-back: next start edge right after the stop sample.
        applyStimulus(2'b11, 1'b1, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b1, 9, 0, 1'b0);
        applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 8'h2A, 1'b0, 1'b1, 16, 16, 1'b0);
        applyStimulus(2'b00, 1'b1, 1'b1, 1'b1, 8'h15, 1'b0, 1'b1, 16, 16, 1'b0);

        // Reset during bit 4 of 0xFF: no push, outputs cleared immediately.
        cfg_word_len  = 2'b11;
        cfg_parity_en = 1'b0;
        driveLevel(1'b0, 16);
        driveLevel(1'b1, 16 * 4 + 8);
        checkOutput("busy_mid_frame", 32'(rx_busy), 32'd1);
        #4 rst_n = 1'b0;
        #1;
        err_obs = rx_if.rx_err;
        checkOutput("midrst_valid", 32'(rx_if.rx_valid), 32'd0);
        checkOutput("midrst_data",  32'(rx_if.rx_data),  32'd0);
        checkOutput("midrst_err",   32'(err_obs),        32'd0);
        checkOutput("midrst_busy",  32'(rx_busy),        32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        nextTick();
        driveLevel(1'b1, 16);
        applyStimulus(2'b11, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 16, 16, 1'b0);

`ifdef UART_RX_MAJORITY_VOTE_EN
        applyStimulus(2'b11, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 16, 16, 1'b1);
        applyStimulus(2'b11, 1'b0, 1'b0, 1'b0, 8'hA7, 1'b0, 1'b1, 16, 16, 1'b1);
`endif

        $display("[TB] randomized frames");
        for (int i = 0; i < 20; i++) begin
            r_len   = 2'($urandom_range(0, 3));
            r_pen   = 1'($urandom_range(0, 1));
            r_even  = 1'($urandom_range(0, 1));
            r_stick = ($urandom_range(0, 3) == 0);
            r_data  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            r_pbit  = 1'($urandom_range(0, 1));
            r_stop  = ($urandom_range(0, 4) != 0);
            if (r_stop) begin
                r_stop_ticks = ($urandom_range(0, 2) == 0) ? int'($urandom_range(9, 16)) : 16;
                r_gap        = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 24));
            end else begin
                r_stop_ticks = 16;
                r_gap        = 16 + int'($urandom_range(0, 8));
            end
            applyStimulus(r_len, r_pen, r_even, r_stick, r_data, r_pbit, r_stop,
                          r_stop_ticks, r_gap, 1'b0);
        end

        for (int i = 0; i < 400 && exp_q.size() != 0; i++) nextTick();
        checkOutput("pending_pushes", 32'(exp_q.size()), 32'd0);
        driveLevel(1'b1, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
